// File: rtl/jk_excite_gen_pkg.sv
// Shared encodings for the JK excitation generator: request modes and FSM states.
package jk_pkg;
  typedef enum logic [1:0] {
    JK_LOAD  = 2'b00,
    JK_UP    = 2'b01,
    JK_DOWN  = 2'b10,
    JK_CLEAR = 2'b11
  } jk_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RUN   = 2'b10,
    S_FIN   = 2'b11
  } jk_state_e;
endpackage

// File: rtl/jk_excite_gen_if.sv
// Request side, JK-bank side and status signals of jk_excite_gen.
interface jk_excite_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             jk_valid;
  logic             jk_ready;
  logic [WIDTH-1:0] q_shadow;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output req_valid, req_mode, req_data, jk_ready,
    input  req_ready, J, K, jk_valid, q_shadow, busy, done, cmd_count
  );

  modport slave (
    input  req_valid, req_mode, req_data, jk_ready,
    output req_ready, J, K, jk_valid, q_shadow, busy, done, cmd_count
  );
endinterface

// File: rtl/jk_excite_gen_excite.sv
// Per-bit JK excitation: (current, next) -> (J, K); TOGGLE_PREF picks set/reset or toggle.
module jk_excite #(
  parameter int WIDTH       = 8,
  parameter int TOGGLE_PREF = 0
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] nxt_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (TOGGLE_PREF != 0) begin : g_tog
      assign j_o[i] = cur_i[i] ^ nxt_i[i];
      assign k_o[i] = cur_i[i] ^ nxt_i[i];
    end else begin : g_sr
      assign j_o[i] = ~cur_i[i] & nxt_i[i];
      assign k_o[i] = cur_i[i] & ~nxt_i[i];
    end
  end
endmodule

// File: rtl/jk_excite_gen.sv
// Command-side JK excitation generator: shadows the bank state and issues one J/K word per handshake.
module jk_excite_gen
  import jk_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TOGGLE_PREF = 0,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  jk_excite_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  jk_state_e        state_q, state_d;
  logic             dn_q, dn_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             jk_vld, xfer;
  logic [WIDTH-1:0] nxt, j_raw, k_raw;

  assign jk_vld = (state_q == S_ISSUE) || (state_q == S_RUN);
  assign xfer   = jk_vld & bus.jk_ready;
  // Count steps derive the next word from the shadow, so it stays stable while stalled.
  assign nxt    = (state_q == S_RUN) ? (dn_q ? shadow_q - ONE : shadow_q + ONE) : tgt_q;

  jk_excite #(.WIDTH(WIDTH), .TOGGLE_PREF(TOGGLE_PREF)) u_exc (
    .cur_i(shadow_q),
    .nxt_i(nxt),
    .j_o  (j_raw),
    .k_o  (k_raw)
  );

  always_comb begin
    state_d  = state_q;
    dn_d     = dn_q;
    tgt_d    = tgt_q;
    rem_d    = rem_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (xfer && cnt_q != '1) cnt_d = cnt_q + C_ONE;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          dn_d  = (jk_mode_e'(bus.req_mode) == JK_DOWN);
          rem_d = bus.req_data;
          case (jk_mode_e'(bus.req_mode))
            JK_LOAD: begin
              tgt_d   = bus.req_data;
              state_d = S_ISSUE;
            end
            JK_CLEAR: begin
              tgt_d   = '0;
              state_d = S_ISSUE;
            end
            JK_UP, JK_DOWN: state_d = (bus.req_data == '0) ? S_FIN : S_RUN;
          endcase
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          shadow_d = nxt;
          state_d  = S_FIN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          shadow_d = nxt;
          rem_d    = rem_q - ONE;
          if (rem_q == ONE) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dn_q     <= 1'b0;
      tgt_q    <= '0;
      rem_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dn_q     <= dn_d;
      tgt_q    <= tgt_d;
      rem_q    <= rem_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.jk_valid  = jk_vld;
  assign bus.J         = jk_vld ? j_raw : '0;
  assign bus.K         = jk_vld ? k_raw : '0;
  assign bus.q_shadow  = shadow_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FIN);
  assign bus.cmd_count = cnt_q;
endmodule

// File: tb/tb_jk_excite_gen.sv
// Bench: two generators (set/reset and toggle preference) on shared stimulus, checked against a word-queue model and JK bank models.
module tb_jk_excite_gen;
  localparam int W   = 8;
  localparam int CW0 = 4;
  localparam int CW1 = 16;

  logic         clk = 1'b0, rst = 1'b1, req_valid = 1'b0, jk_ready = 1'b1;
  logic [1:0]   req_mode = 2'd0;
  logic [W-1:0] req_data = '0;

  always #5 clk = ~clk;

  jk_excite_gen_if #(.WIDTH(W), .CNT_W(CW0)) if0 ();
  jk_excite_gen_if #(.WIDTH(W), .CNT_W(CW1)) if1 ();
  assign if0.req_valid = req_valid;
  assign if0.req_mode  = req_mode;
  assign if0.req_data  = req_data;
  assign if0.jk_ready  = jk_ready;
  assign if1.req_valid = req_valid;
  assign if1.req_mode  = req_mode;
  assign if1.req_data  = req_data;
  assign if1.jk_ready  = jk_ready;

  jk_excite_gen #(.WIDTH(W), .TOGGLE_PREF(0), .CNT_W(CW0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  jk_excite_gen #(.WIDTH(W), .TOGGLE_PREF(1), .CNT_W(CW1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int checks = 0, errors = 0;
  bit chk_en = 0, rnd_rdy = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(string tag);
    checks++;
    errors++;
    $error("FAIL timeout_%s observed=waiting expected=event", tag);
  endtask

  function automatic int exp_j(int cur, int nxt, bit tp);
    return tp ? ((cur ^ nxt) & 255) : (nxt & ~cur & 255);
  endfunction
  function automatic int exp_k(int cur, int nxt, bit tp);
    return tp ? ((cur ^ nxt) & 255) : (cur & ~nxt & 255);
  endfunction

  // Model: queue of bank words still to be issued, expected shadow, done-pending flag, counters.
  int           wq[$];
  int           ref_q = 0, cnt0 = 0, cnt1 = 0;
  bit           fin = 0;
  logic [W-1:0] bank0 = '0, bank1 = '0;

  always @(negedge clk) begin : model
    bit v, fin_n;
    int nx, t;
    v  = (wq.size() > 0);
    nx = v ? wq[0] : 0;
    if (chk_en) begin
      check("ready0",  if0.req_ready, !(v || fin));
      check("ready1",  if1.req_ready, !(v || fin));
      check("busy0",   if0.busy, v || fin);
      check("busy1",   if1.busy, v || fin);
      check("done0",   if0.done, fin);
      check("done1",   if1.done, fin);
      check("jkv0",    if0.jk_valid, v);
      check("jkv1",    if1.jk_valid, v);
      check("J0",      if0.J, v ? exp_j(ref_q, nx, 0) : 0);
      check("K0",      if0.K, v ? exp_k(ref_q, nx, 0) : 0);
      check("J1",      if1.J, v ? exp_j(ref_q, nx, 1) : 0);
      check("K1",      if1.K, v ? exp_k(ref_q, nx, 1) : 0);
      check("shadow0", if0.q_shadow, ref_q);
      check("shadow1", if1.q_shadow, ref_q);
      check("bank0",   bank0, if0.q_shadow);
      check("bank1",   bank1, if1.q_shadow);
      check("cnt0",    if0.cmd_count, cnt0);
      check("cnt1",    if1.cmd_count, cnt1);
    end
    fin_n = 0;
    if (rst) begin
      wq.delete();
      ref_q = 0; cnt0 = 0; cnt1 = 0; fin = 0;
      bank0 = '0; bank1 = '0;
    end else begin
      if (v && jk_ready) begin
        bank0 = (if0.J & ~bank0) | (~if0.K & bank0);
        bank1 = (if1.J & ~bank1) | (~if1.K & bank1);
        ref_q = wq.pop_front();
        cnt0  = (cnt0 < (1 << CW0) - 1) ? cnt0 + 1 : cnt0;
        cnt1  = (cnt1 < (1 << CW1) - 1) ? cnt1 + 1 : cnt1;
        if (wq.size() == 0) fin_n = 1;
      end else if (!v && !fin && req_valid) begin
        t = ref_q;
        case (req_mode)
          2'd0: wq.push_back(int'(req_data));
          2'd3: wq.push_back(0);
          2'd1: repeat (int'(req_data)) begin t = (t + 1) % 256; wq.push_back(t); end
          default: repeat (int'(req_data)) begin t = (t + 255) % 256; wq.push_back(t); end
        endcase
        if (wq.size() == 0) fin_n = 1;
      end
      fin = fin_n;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rnd_rdy) jk_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(int m, int d);
    int n = 0;
    while (!if0.req_ready && n < 600) begin cycle(); n++; end
    if (n >= 600) timeout("req");
    req_valid = 1'b1;
    req_mode  = 2'(m);
    req_data  = W'(d);
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if0.busy || if0.done) && n < 600) begin cycle(); n++; end
    if (n >= 600) timeout("idle");
  endtask

  initial begin
    @(posedge clk);
    #1 chk_en = 1;
    cycle();
    rst = 1'b0;
    // Directed: loads, set/reset vs toggle excitation
    do_req(0, 'hA5); wait_idle();
    check("t1_shadow", if0.q_shadow, 'hA5);
    check("t1_cnt", if0.cmd_count, 1);
    do_req(0, 'h5A); wait_idle();
    // Count sequences across the wrap points
    do_req(0, 'hFE); wait_idle();
    do_req(1, 3);    wait_idle();
    check("t3_up", if0.q_shadow, 'h01);
    do_req(2, 2);    wait_idle();
    check("t3_down", if0.q_shadow, 'hFF);
    // Stall mid-count
    do_req(1, 5);
    jk_ready = 1'b0;
    repeat (4) cycle();
    jk_ready = 1'b1;
    wait_idle();
    check("t4_stall", if1.q_shadow, 'h04);
    // Zero-length count, then a request ignored while busy
    do_req(1, 0); wait_idle();
    do_req(1, 3);
    req_valid = 1'b1; req_mode = 2'd0; req_data = 'h33;
    repeat (2) cycle();
    req_valid = 1'b0;
    wait_idle();
    check("t5_ignored", if0.q_shadow, 'h07);
    // Load equal to shadow, then clear
    do_req(0, 'h07); wait_idle();
    do_req(3, 'h99); wait_idle();
    check("t_clear", if0.q_shadow, 0);
    // Reset during a count
    do_req(1, 5);
    cycle();
    rst = 1'b1;
    cycle();
    check("t6_shadow", if0.q_shadow, 0);
    check("t6_ready", if0.req_ready, 1);
    check("t6_cnt", if1.cmd_count, 0);
    rst = 1'b0;
    // Random requests with random bank back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      int m, d;
      m = int'($urandom_range(0, 3));
      d = (m == 1 || m == 2) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 255));
      do_req(m, d);
      repeat ($urandom_range(0, 2)) cycle();
    end
    rnd_rdy = 0;
    jk_ready = 1'b1;
    wait_idle();
    cycle();
    check("sat_cnt0", if0.cmd_count, (1 << CW0) - 1);
    check("end_cnt1", if1.cmd_count, cnt1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
